// File: rtl/clk_synth_model.sv
// clk_synth_model: cycle-accurate fractional clock-synthesis model.
// A 32-bit phase accumulator adds MULT every enabled CLKIN1 cycle and wraps
// at MOD = DIVCLK*OUT_DIV. Each wrap produces a one-cycle CLK_EN_OUT pulse,
// so the average pulse rate is f_in*MULT/(DIVCLK*OUT_DIV). CLK_OUT toggles
// once per pulse. A saturating counter models lock acquisition.
// Optional feature macro: CLK_SYNTH_OUT_GATE_EN. When it is defined, the
// accumulator and both clock outputs are held at 0 until LOCKED is high.
module clk_synth_model #(
  parameter int unsigned MULT        = 5,
  parameter int unsigned DIVCLK      = 1,
  parameter int unsigned OUT_DIV     = 10,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic CLKIN1,
  input  logic RST,
  input  logic PWRDWN,
  output logic CLK_EN_OUT,
  output logic CLK_OUT,
  output logic LOCKED,
  output logic PARAM_ERR
);

  localparam int unsigned MOD = DIVCLK * OUT_DIV;

  // Illegal parameter set: any value out of range, or a ratio above 1.
  localparam logic PERR_C = ((MULT < 32'd2) || (MULT > 32'd64) ||
                             (DIVCLK < 32'd1) || (DIVCLK > 32'd106) ||
                             (OUT_DIV < 32'd1) || (OUT_DIV > 32'd128) ||
                             (LOCK_CYCLES < 32'd1) || (LOCK_CYCLES > 32'd65535) ||
                             (MULT > MOD)) ? 1'b1 : 1'b0;

  localparam logic [31:0] MULT_W = 32'(MULT);
  localparam logic [31:0] MOD_W  = 32'(MOD);
  localparam logic [15:0] LOCK_W = 16'(LOCK_CYCLES);

  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q,   locked_d;
  logic [31:0] acc_q,      acc_d;
  logic        en_q,       en_d;
  logic        clk_out_q,  clk_out_d;
  logic [31:0] nxt_s;
  logic        run_s;

  // Lock counter: counts up while running, saturates, clears on power-down.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (PWRDWN || PERR_C) begin
      lock_cnt_d = 16'd0;
      locked_d   = 1'b0;
    end else begin
      if (lock_cnt_q != LOCK_W) begin
        lock_cnt_d = lock_cnt_q + 16'd1;
      end else begin
        lock_cnt_d = lock_cnt_q;
      end
      locked_d = (lock_cnt_d == LOCK_W) ? 1'b1 : 1'b0;
    end
  end

  // Phase accumulator, wrap detection and output toggle.
  always_comb begin
`ifdef CLK_SYNTH_OUT_GATE_EN
    run_s = locked_q;
`else
    run_s = 1'b1;
`endif
    nxt_s     = acc_q + MULT_W;
    acc_d     = acc_q;
    en_d      = 1'b0;
    clk_out_d = clk_out_q;
    if (PWRDWN || PERR_C) begin
      acc_d     = 32'd0;
      en_d      = 1'b0;
      clk_out_d = 1'b0;
    end else if (run_s) begin
      // CLK_OUT follows the pulse registered on the previous edge.
      clk_out_d = clk_out_q ^ en_q;
      if (nxt_s >= MOD_W) begin
        acc_d = nxt_s - MOD_W;
        en_d  = 1'b1;
      end else begin
        acc_d = nxt_s;
        en_d  = 1'b0;
      end
    end else begin
      acc_d     = 32'd0;
      en_d      = 1'b0;
      clk_out_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      lock_cnt_q <= 16'd0;
      locked_q   <= 1'b0;
      acc_q      <= 32'd0;
      en_q       <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      acc_q      <= acc_d;
      en_q       <= en_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign CLK_EN_OUT = en_q;
  assign CLK_OUT    = clk_out_q;
  assign LOCKED     = locked_q;
  assign PARAM_ERR  = PERR_C;

endmodule

// File: tb/tb_clk_synth_model.sv
// Self-checking bench for clk_synth_model. Four instances cover the default
// ratio, a fractional ratio (3/10), ratio exactly 1 (10/10) and an illegal
// ratio (11/10). Expected values come from a hand-written table for the
// default instance and from a closed-form floor() model for every instance.
// Cycle n = value sampled just after the n-th rising edge since RST release.
module tb_clk_synth_model;

  logic clk = 1'b0;
  logic rst;
  logic pwrdwn;

  logic en_def,  co_def,  lk_def,  pe_def;
  logic en_frac, co_frac, lk_frac, pe_frac;
  logic en_full, co_full, lk_full, pe_full;
  logic en_err,  co_err,  lk_err,  pe_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int frac_hist[$];

  always #5 clk = ~clk;

  clk_synth_model u_def (
    .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn),
    .CLK_EN_OUT(en_def), .CLK_OUT(co_def), .LOCKED(lk_def), .PARAM_ERR(pe_def));

  clk_synth_model #(.MULT(3), .DIVCLK(2), .OUT_DIV(5), .LOCK_CYCLES(64)) u_frac (
    .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn),
    .CLK_EN_OUT(en_frac), .CLK_OUT(co_frac), .LOCKED(lk_frac), .PARAM_ERR(pe_frac));

  clk_synth_model #(.MULT(10), .DIVCLK(1), .OUT_DIV(10), .LOCK_CYCLES(64)) u_full (
    .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn),
    .CLK_EN_OUT(en_full), .CLK_OUT(co_full), .LOCKED(lk_full), .PARAM_ERR(pe_full));

  clk_synth_model #(.MULT(11), .DIVCLK(1), .OUT_DIV(10), .LOCK_CYCLES(64)) u_err (
    .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn),
    .CLK_EN_OUT(en_err), .CLK_OUT(co_err), .LOCKED(lk_err), .PARAM_ERR(pe_err));

  typedef struct {
    int   cyc;
    logic en;
    logic co;
    logic lk;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Number of accumulation steps taken after n edges since release.
  function automatic int steps(input int n, input int lockc);
`ifdef CLK_SYNTH_OUT_GATE_EN
    return (n > lockc) ? (n - lockc) : 0;
`else
    return n;
`endif
  endfunction

  // Closed-form expectation: pulse on step k when floor(k*M/MOD) advances;
  // CLK_OUT parity = number of pulses registered on steps 1..k-1.
  task automatic model(input int n, input int m, input int modv, input int lockc,
                       output logic en, output logic co, output logic lk);
    int k;
    k  = steps(n, lockc);
    lk = (n >= lockc);
    en = (k >= 1) && (((k * m) / modv) != (((k - 1) * m) / modv));
    co = (k >= 1) && (((((k - 1) * m) / modv) % 2) == 1);
  endtask

  task automatic check_all(input int n, input string tag);
    logic e, c, l;
    int   cnt;
    model(n, 5, 10, 64, e, c, l);
    chk($sformatf("%s def_en n=%0d", tag, n), en_def, e);
    chk($sformatf("%s def_clk n=%0d", tag, n), co_def, c);
    chk($sformatf("%s def_lock n=%0d", tag, n), lk_def, l);
    model(n, 3, 10, 64, e, c, l);
    chk($sformatf("%s frac_en n=%0d", tag, n), en_frac, e);
    chk($sformatf("%s frac_clk n=%0d", tag, n), co_frac, c);
    chk($sformatf("%s frac_lock n=%0d", tag, n), lk_frac, l);
    model(n, 10, 10, 64, e, c, l);
    chk($sformatf("%s full_en n=%0d", tag, n), en_full, e);
    chk($sformatf("%s full_clk n=%0d", tag, n), co_full, c);
    chk($sformatf("%s full_lock n=%0d", tag, n), lk_full, l);
    chk($sformatf("%s err_en n=%0d", tag, n), en_err, 1'b0);
    chk($sformatf("%s err_clk n=%0d", tag, n), co_err, 1'b0);
    chk($sformatf("%s err_lock n=%0d", tag, n), lk_err, 1'b0);
    // Fractional instance: exactly 3 pulses in any 10 consecutive steps.
    frac_hist.push_back(int'(en_frac === 1'b1));
    if (frac_hist.size() > 10) void'(frac_hist.pop_front());
    if (steps(n, 64) >= 10) begin
      cnt = 0;
      foreach (frac_hist[i]) cnt += frac_hist[i];
      tests_run++;
      if (cnt != 3) begin
        tests_failed++;
        $display("FAIL %s frac_window n=%0d: got %0d pulses, expected 3", tag, n, cnt);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " def_en"}, en_def, 1'b0);
    chk({tag, " def_clk"}, co_def, 1'b0);
    chk({tag, " def_lock"}, lk_def, 1'b0);
    chk({tag, " frac_en"}, en_frac, 1'b0);
    chk({tag, " full_en"}, en_full, 1'b0);
    chk({tag, " full_clk"}, co_full, 1'b0);
    chk({tag, " err_lock"}, lk_err, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef CLK_SYNTH_OUT_GATE_EN
    tbl[0] = '{2,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{4,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{63, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{64, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{65, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{66, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{67, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{68, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{69, 1'b0, 1'b0, 1'b1};
`else
    tbl[0] = '{1,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{2,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{3,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{4,  1'b1, 1'b1, 1'b0};
    tbl[4] = '{5,  1'b0, 1'b0, 1'b0};
    tbl[5] = '{6,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{7,  1'b0, 1'b1, 1'b0};
    tbl[7] = '{63, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{64, 1'b1, 1'b1, 1'b1};
`endif

    rst    = 1'b1;
    pwrdwn = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Reset state and static parameter flags.
    check_cleared("reset");
    chk("perr_def", pe_def, 1'b0);
    chk("perr_frac", pe_frac, 1'b0);
    chk("perr_full", pe_full, 1'b0);
    chk("perr_err", pe_err, 1'b1);

    // Run 100 cycles from reset release: table rows plus model everywhere.
    rst = 1'b0;
    frac_hist.delete();
    for (int n = 1; n <= 100; n++) begin
      tick();
      for (int r = 0; r < 9; r++) begin
        if (tbl[r].cyc == n) begin
          chk($sformatf("tbl_en c=%0d", n), en_def, tbl[r].en);
          chk($sformatf("tbl_clk c=%0d", n), co_def, tbl[r].co);
          chk($sformatf("tbl_lock c=%0d", n), lk_def, tbl[r].lk);
        end
      end
      check_all(n, "run");
    end

    // One-cycle power-down: everything clears on the next edge.
    pwrdwn = 1'b1;
    tick();
    check_cleared("pwrdwn");
    chk("pwrdwn perr_err", pe_err, 1'b1);
    pwrdwn = 1'b0;
    frac_hist.delete();
    for (int n = 1; n <= 80; n++) begin
      tick();
      check_all(n, "relock");
    end

    // RST alone mid-operation aborts the pattern; restart is clean.
    rst = 1'b1;
    tick();
    check_cleared("rst_abort");
    rst = 1'b0;
    frac_hist.delete();
    for (int n = 1; n <= 12; n++) begin
      tick();
      check_all(n, "after_rst");
    end

    // RST and PWRDWN together give the same cleared state.
    rst    = 1'b1;
    pwrdwn = 1'b1;
    tick();
    check_cleared("rst_pwrdwn");
    rst    = 1'b0;
    pwrdwn = 1'b0;
    frac_hist.delete();
    for (int n = 1; n <= 8; n++) begin
      tick();
      check_all(n, "after_both");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
